// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU step/run clock controller.
package cpu_clk_pkg;

    // Operator-selected mode encodings
    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // Controller FSM states; the encoding is shown directly on led[15:14]
    typedef enum logic [1:0] {
        ST_HOLD  = 2'b00,
        ST_IDLE  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BURST = 2'b11
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DB_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);

    logic [1:0]      sync_reg;
    logic [DB_W-1:0] cnt_reg;
    logic            level_reg;
    logic            rise_reg;

    // Bring the raw button into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_in};
        end
    end

    // Accept a new level only after it has differed for 2^DB_W straight cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            if (sync_reg[1] != level_reg) begin
                if (&cnt_reg) begin
                    level_reg <= sync_reg[1];
                    rise_reg  <= sync_reg[1];
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DB_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign btn_level = level_reg;
    assign btn_rise  = rise_reg;

endmodule

// File: rtl/cpu_step_clock_ctrl.sv
// Clock-enable and reset sequencer for a CPU pipeline: halt, free run,
// single step from a push-button, and fixed-length bursts, with a cycle
// counter and status LEDs.
module cpu_step_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 4,
    parameter int DB_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             clr_cnt,
    output logic             core_rst,
    output logic             core_ce,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             ovf,
    output logic [15:0]      led
);

    localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [7:0]       hold_reg, hold_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic             core_ce_reg, ce_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic [1:0]       mode_reg;
    logic             btn_level;
    logic             btn_rise;
    logic             step_fire;
    logic [11:0]      cnt_disp;

    btn_debounce #(
        .DB_W(DB_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (step_btn),
        .btn_level(btn_level),
        .btn_rise (btn_rise)
    );

    // Rise pulse qualified by the settled level it produced
    assign step_fire = btn_rise & btn_level;

    // FSM, hold counter, burst counter and the registered clock enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_HOLD;
            hold_reg    <= 8'd0;
            rem_reg     <= '0;
            core_ce_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            rem_reg     <= rem_next;
            core_ce_reg <= ce_next;
        end
    end

    // Next state; ce_next is the enable for the cycle after this edge
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        rem_next   = rem_reg;
        ce_next    = 1'b0;
        case (state_reg)
            ST_HOLD: begin
                if (hold_reg == HOLD_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    hold_next = hold_reg + 8'd1;
                end
            end
            ST_IDLE: begin
                case (mode)
                    MODE_RUN: begin
                        state_next = ST_RUN;
                        ce_next    = 1'b1;
                    end
                    MODE_BURST: begin
                        // The entry edge already issues the first enable
                        if (start && (burst_len != '0)) begin
                            state_next = ST_BURST;
                            rem_next   = burst_len - CNT_W'(1);
                            ce_next    = 1'b1;
                        end
                    end
                    MODE_STEP: begin
                        ce_next = step_fire;
                    end
                    default: begin
                        ce_next = 1'b0;
                    end
                endcase
            end
            ST_RUN: begin
                if (mode == MODE_RUN) begin
                    ce_next = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BURST: begin
                if ((mode != MODE_BURST) || (rem_reg == '0)) begin
                    state_next = ST_IDLE;
                    rem_next   = '0;
                end else begin
                    rem_next = rem_reg - CNT_W'(1);
                    ce_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

    // Count issued enables; a clear in the same cycle takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (core_ce_reg) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (&cnt_reg) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Registered copy of mode so the LEDs read all-zero during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg <= 2'b00;
        end else begin
            mode_reg <= mode;
        end
    end

    // Low 12 counter bits for the LEDs, zero-filled when CNT_W is narrower
    for (genvar gi = 0; gi < 12; gi++) begin : g_disp
        if (gi < CNT_W) begin : g_bit
            assign cnt_disp[gi] = cnt_reg[gi];
        end else begin : g_zero
            assign cnt_disp[gi] = 1'b0;
        end
    end

    assign core_rst  = (state_reg == ST_HOLD);
    assign core_ce   = core_ce_reg;
    assign busy      = (state_reg == ST_RUN) || (state_reg == ST_BURST);
    assign cycle_cnt = cnt_reg;
    assign ovf       = ovf_reg;
    assign led       = {state_reg, mode_reg, cnt_disp};

endmodule

// File: tb/tb_cpu_step_clock_ctrl.sv
// Directed bench for cpu_step_clock_ctrl (CNT_W=4, RST_CYCLES=4, DB_W=2).
module tb_cpu_step_clock_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        step_btn;
    logic        start;
    logic [3:0]  burst_len;
    logic        clr_cnt;
    logic        core_rst;
    logic        core_ce;
    logic        busy;
    logic [3:0]  cycle_cnt;
    logic        ovf;
    logic [15:0] led;

    int checks;
    int failures;

    cpu_step_clock_ctrl #(
        .CNT_W     (4),
        .RST_CYCLES(4),
        .DB_W      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .step_btn (step_btn),
        .start    (start),
        .burst_len(burst_len),
        .clr_cnt  (clr_cnt),
        .core_rst (core_rst),
        .core_ce  (core_ce),
        .busy     (busy),
        .cycle_cnt(cycle_cnt),
        .ovf      (ovf),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counter();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; step_btn = 1'b0; start = 1'b0;
        burst_len = 4'd0; clr_cnt = 1'b0;
        #1;
        checks++;
        if ({core_rst, core_ce, busy, ovf} !== 4'b1000 || cycle_cnt !== 4'd0 || led !== 16'h0000) begin
            failures++;
            $display("FAIL reset_values rst/ce/busy/ovf=%b cnt=%0d led=%h required 1000 0 0000",
                     {core_rst, core_ce, busy, ovf}, cycle_cnt, led);
        end
        tick(); tick(); tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (core_rst !== (i < 4) || core_ce !== 1'b0) begin
                failures++;
                $display("FAIL hold_seq edge=%0d core_rst=%b core_ce=%b required %b 0",
                         i, core_rst, core_ce, (i < 4));
            end
        end
        $display("reset: hold sequence released after 4 edges");
    endtask

    task automatic test_halt();
        mode = 2'b00;
        tick(); tick();
        checks++;
        if (core_ce !== 1'b0 || busy !== 1'b0 || led !== 16'h4000) begin
            failures++;
            $display("FAIL halt ce=%b busy=%b led=%h required 0 0 4000", core_ce, busy, led);
        end
        $display("halt: idle with enable low");
    endtask

    task automatic test_run_wrap();
        clear_counter();
        mode = 2'b01;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) begin
                checks++;
                if (core_ce !== 1'b1 || busy !== 1'b1 || cycle_cnt !== 4'd0) begin
                    failures++;
                    $display("FAIL run_entry ce=%b busy=%b cnt=%0d required 1 1 0", core_ce, busy, cycle_cnt);
                end
            end
            if (k == 16) begin
                checks++;
                if (cycle_cnt !== 4'd15 || ovf !== 1'b0 || led !== 16'h900F) begin
                    failures++;
                    $display("FAIL run_pre_wrap cnt=%0d ovf=%b led=%h required 15 0 900f", cycle_cnt, ovf, led);
                end
            end
        end
        checks++;
        if (cycle_cnt !== 4'd0 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL run_wrap cnt=%0d ovf=%b required 0 1", cycle_cnt, ovf);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (cycle_cnt !== 4'd0 || ovf !== 1'b0 || core_ce !== 1'b1) begin
            failures++;
            $display("FAIL clr_wins cnt=%0d ovf=%b ce=%b required 0 0 1", cycle_cnt, ovf, core_ce);
        end
        tick();
        checks++;
        if (cycle_cnt !== 4'd1) begin
            failures++;
            $display("FAIL run_after_clr cnt=%0d required 1", cycle_cnt);
        end
        mode = 2'b00;
        tick();
        checks++;
        if (core_ce !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 4'd2) begin
            failures++;
            $display("FAIL run_exit ce=%b busy=%b cnt=%0d required 0 0 2", core_ce, busy, cycle_cnt);
        end
        $display("run: counter wrapped with overflow, clear took priority");
    endtask

    task automatic test_burst();
        int ce_seen;
        int busy_bad;
        mode = 2'b11;
        clear_counter();
        burst_len = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        ce_seen = 0;
        busy_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_ce === 1'b1) ce_seen++;
            if (busy !== core_ce) busy_bad++;
            if (i == 1) begin start = 1'b1; burst_len = 4'd3; end
            if (i == 2) start = 1'b0;
            tick();
        end
        checks++;
        if (ce_seen != 5 || cycle_cnt !== 4'd5 || busy_bad != 0) begin
            failures++;
            $display("FAIL burst5 ce_cycles=%0d cnt=%0d busy_mismatch=%0d required 5 5 0",
                     ce_seen, cycle_cnt, busy_bad);
        end
        $display("burst: len=5 issued %0d enables", ce_seen);
    endtask

    task automatic test_burst_zero();
        burst_len = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (core_ce !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 4'd5) begin
            failures++;
            $display("FAIL burst_zero ce=%b busy=%b cnt=%0d required 0 0 5", core_ce, busy, cycle_cnt);
        end
        $display("burst: zero length start ignored");
    endtask

    task automatic test_burst_abort();
        mode = 2'b11;
        clear_counter();
        burst_len = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (core_ce !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_mid ce=%b busy=%b required 1 1", core_ce, busy);
        end
        mode = 2'b00;
        tick();
        checks++;
        if (core_ce !== 1'b0 || busy !== 1'b0 || (cycle_cnt !== 4'd3 && cycle_cnt !== 4'd4)) begin
            failures++;
            $display("FAIL abort ce=%b busy=%b cnt=%0d required 0 0 3or4", core_ce, busy, cycle_cnt);
        end
        $display("burst: abort after 3 enables, cnt=%0d", cycle_cnt);
    endtask

    task automatic test_step();
        int pulses;
        mode = 2'b10;
        clear_counter();
        pulses = 0;
        step_btn = 1'b1; tick(); if (core_ce === 1'b1) pulses++;
        step_btn = 1'b0; tick(); if (core_ce === 1'b1) pulses++;
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (core_ce === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || cycle_cnt !== 4'd1) begin
            failures++;
            $display("FAIL step_press pulses=%0d cnt=%0d required 1 1", pulses, cycle_cnt);
        end
        pulses = 0;
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (core_ce === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || cycle_cnt !== 4'd1) begin
            failures++;
            $display("FAIL step_release pulses=%0d cnt=%0d required 0 1", pulses, cycle_cnt);
        end
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (core_ce === 1'b1) pulses++;
        end
        step_btn = 1'b0;
        checks++;
        if (pulses != 1 || cycle_cnt !== 4'd2) begin
            failures++;
            $display("FAIL step_second pulses=%0d cnt=%0d required 1 2", pulses, cycle_cnt);
        end
        $display("step: one enable per debounced press, cnt=%0d", cycle_cnt);
    endtask

    task automatic test_reset_midrun();
        mode = 2'b01;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1 || core_ce !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre busy=%b ce=%b required 1 1", busy, core_ce);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({core_rst, core_ce, busy, ovf} !== 4'b1000 || cycle_cnt !== 4'd0 || led !== 16'h0000) begin
            failures++;
            $display("FAIL midrun_async rst/ce/busy/ovf=%b cnt=%0d led=%h required 1000 0 0000",
                     {core_rst, core_ce, busy, ovf}, cycle_cnt, led);
        end
        mode = 2'b00;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (core_rst !== (i < 4) || core_ce !== 1'b0) begin
                failures++;
                $display("FAIL midrun_hold edge=%0d core_rst=%b core_ce=%b required %b 0",
                         i, core_rst, core_ce, (i < 4));
            end
        end
        checks++;
        if (led !== 16'h4000) begin
            failures++;
            $display("FAIL midrun_idle led=%h required 4000", led);
        end
        $display("reset: mid-run reset cleared outputs and repeated hold");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_halt();
        test_run_wrap();
        test_burst();
        test_burst_zero();
        test_burst_abort();
        test_step();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
